// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA burst sequencer.
package dma_pkg;

  // Bursts may not cross this address boundary.
  localparam int BOUNDARY_BYTES = 4096;
  localparam int OFFS_W         = $clog2(BOUNDARY_BYTES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CALC    = 3'd1,
    ISSUE   = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4
  } dma_state_e;

  // Burst command as presented to the DMA channel (address carried separately).
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
  } burst_cmd_t;

endpackage

// File: rtl/dma_burst_calc.sv
// Burst length: min(remaining beats, MAX_BURST, beats left before the 4 KB boundary).
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int BEATS_WIDTH = 16,
  parameter int MAX_BURST   = 256
) (
  input  logic [OFFS_W-1:0]      addr,
  input  logic [BEATS_WIDTH-1:0] remaining,
  input  logic [2:0]             size,
  output logic [8:0]             burst
);

  // Wide enough for the boundary constant and the remaining count.
  localparam int CW = (BEATS_WIDTH > OFFS_W + 1) ? BEATS_WIDTH : OFFS_W + 1;

  logic [CW-1:0] to_4k;
  logic [CW-1:0] lim;

  // Address is size-aligned, so to_4k is never zero.
  always_comb begin
    to_4k = (CW'(BOUNDARY_BYTES) - CW'(addr)) >> size;
    lim   = CW'(remaining);
    if (CW'(MAX_BURST) < lim) lim = CW'(MAX_BURST);
    if (to_4k < lim)          lim = to_4k;
    burst = 9'(lim);
  end

endmodule

// File: rtl/dma_burst_sequencer.sv
// Splits a DMA job into bursts that respect MAX_BURST and the 4 KB boundary.
// One instance drives one channel; read and write paths each get their own.
module dma_burst_sequencer
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int BEATS_WIDTH = 16,
  parameter int MAX_BURST   = 256
) (
  input  logic                   m_axi_aclk,
  input  logic                   m_axi_aresetn,
  input  logic                   job_valid_i,
  output logic                   job_ready_o,
  input  logic [ADDR_WIDTH-1:0]  job_addr_i,
  input  logic [BEATS_WIDTH-1:0] job_beats_i,
  input  logic [2:0]             job_size_i,
  output logic                   dma_start_o,
  output logic [ADDR_WIDTH-1:0]  dma_addr_o,
  output logic [7:0]             dma_len_o,
  output logic [2:0]             dma_size_o,
  input  logic                   dma_busy_i,
  output logic                   busy_o,
  output logic                   done_o
);

  dma_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BEATS_WIDTH-1:0] rem_q, rem_d;
  logic [2:0]             size_q, size_d;
  logic [8:0]             burst_q, burst_d;
  logic [ADDR_WIDTH-1:0]  cmd_addr_q, cmd_addr_d;
  burst_cmd_t             cmd_q, cmd_d;
  logic                   done_q, done_d;
  logic [8:0]             burst_c;

  dma_burst_calc #(
    .BEATS_WIDTH (BEATS_WIDTH),
    .MAX_BURST   (MAX_BURST)
  ) u_calc (
    .addr      (addr_q[OFFS_W-1:0]),
    .remaining (rem_q),
    .size      (size_q),
    .burst     (burst_c)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    size_d     = size_q;
    burst_d    = burst_q;
    cmd_addr_d = cmd_addr_q;
    cmd_d      = cmd_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (job_valid_i) begin
          if (job_beats_i == '0) begin
            // Empty job: acknowledge completion without touching the channel.
            done_d = 1'b1;
          end else begin
            addr_d  = job_addr_i & ({ADDR_WIDTH{1'b1}} << job_size_i);
            rem_d   = job_beats_i;
            size_d  = job_size_i;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // Command fields are latched here so they stay stable until the next start.
        burst_d    = burst_c;
        cmd_addr_d = addr_q;
        cmd_d.len  = 8'(burst_c - 9'd1);
        cmd_d.size = size_q;
        state_d    = ISSUE;
      end
      ISSUE: begin
        addr_d  = addr_q + (ADDR_WIDTH'(burst_q) << size_q);
        rem_d   = rem_q - BEATS_WIDTH'(burst_q);
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (dma_busy_i) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!dma_busy_i) begin
          if (rem_q != '0) begin
            state_d = CALC;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any job in flight.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      cmd_addr_q <= '0;
      cmd_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_q      <= cmd_d;
      done_q     <= done_d;
    end
  end

  assign job_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign dma_start_o = (state_q == ISSUE);
  assign dma_addr_o  = cmd_addr_q;
  assign dma_len_o   = cmd_q.len;
  assign dma_size_o  = cmd_q.size;
  assign done_o      = done_q;

endmodule
